// File: rtl/mux_arb_pkg.sv
// Shared definitions for the mux request arbiter.
//   state_t          : sequencer state encoding
//   OP_W / SEL_W     : engine operand and select widths
//   DEFAULT_TIMEOUT  : default number of WAIT cycles before an error response
package mux_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  localparam int OP_W            = 4;
  localparam int SEL_W           = 2;
  localparam int OPS_W           = 4 * OP_W;
  localparam int DEFAULT_TIMEOUT = 15;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
//   req     : per-client request vector
//   ptr     : client with highest priority this round
//   winner  : first requesting client scanning upward from ptr, wrapping
//   any_req : at least one request is present
module rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] winner,
  output logic             any_req
);

  logic [IDX_W-1:0] idx;

  // Scan from the farthest offset down so the closest requester to ptr
  // is the last assignment and therefore wins.
  always_comb begin
    winner  = '0;
    any_req = 1'b0;
    idx     = '0;
    for (int i = N - 1; i >= 0; i--) begin
      idx = IDX_W'((int'(ptr) + i) % N);
      if (req[idx]) begin
        winner  = idx;
        any_req = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_req_arbiter.sv
// Round-robin sequencer sharing one mux_4to1_4bit engine among N clients.
//   clk, rst_n          : clock, async active-low reset
//   req/req_ops/req_sel : client requests, operands {i3,i2,i1,i0}, selects
//   gnt                 : one-hot accept pulse
//   rsp_vld/rsp_y/rsp_err : one-hot response pulse, result, timeout flag
//   busy                : sequencer not idle
//   eng_*               : engine request (i_vld, operands, sel) and result
//
// state    | meaning
// ---------+--------------------------------------------------------
// ST_IDLE  | waiting for any request; arbitrates and latches winner
// ST_ISSUE | gnt and eng_i_vld visible; advance round-robin pointer
// ST_WAIT  | waiting for eng_o_vld, timer counts up to TIMEOUT
// ST_RESP  | rsp_vld/rsp_y/rsp_err visible for the winner
module mux_req_arbiter
  import mux_arb_pkg::*;
#(
  parameter int N       = 4,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N-1:0]        req,
  input  logic [OPS_W*N-1:0]  req_ops,
  input  logic [SEL_W*N-1:0]  req_sel,
  output logic [N-1:0]        gnt,
  output logic [N-1:0]        rsp_vld,
  output logic [OP_W-1:0]     rsp_y,
  output logic                rsp_err,
  output logic                busy,
  output logic                eng_i_vld,
  output logic [OP_W-1:0]     eng_i0,
  output logic [OP_W-1:0]     eng_i1,
  output logic [OP_W-1:0]     eng_i2,
  output logic [OP_W-1:0]     eng_i3,
  output logic [SEL_W-1:0]    eng_sel,
  input  logic [OP_W-1:0]     eng_y,
  input  logic                eng_o_vld
);

  localparam int IDX_W = $clog2(N);

  state_t           state;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] win;
  logic [7:0]       timer;
  logic [IDX_W-1:0] pick;
  logic             any_req;
  logic [OPS_W-1:0] pick_ops;
  logic [SEL_W-1:0] pick_sel;

  rr_pick #(.N(N), .IDX_W(IDX_W)) u_pick (
    .req     (req),
    .ptr     (ptr),
    .winner  (pick),
    .any_req (any_req)
  );

  always_comb begin
    pick_ops = '0;
    pick_sel = '0;
    for (int k = 0; k < N; k++) begin
      if (int'(pick) == k) begin
        pick_ops = req_ops[k*OPS_W +: OPS_W];
        pick_sel = req_sel[k*SEL_W +: SEL_W];
      end
    end
  end

  function automatic logic [N-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [N-1:0] r;
    r = '0;
    for (int k = 0; k < N; k++) begin
      if (int'(idx) == k) r[k] = 1'b1;
    end
    return r;
  endfunction

  assign busy = (state != ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      ptr       <= '0;
      win       <= '0;
      timer     <= '0;
      gnt       <= '0;
      rsp_vld   <= '0;
      rsp_y     <= '0;
      rsp_err   <= 1'b0;
      eng_i_vld <= 1'b0;
      eng_i0    <= '0;
      eng_i1    <= '0;
      eng_i2    <= '0;
      eng_i3    <= '0;
      eng_sel   <= '0;
    end else begin
      // Pulses default low; eng_i*/eng_sel and rsp_y hold between requests.
      gnt       <= '0;
      eng_i_vld <= 1'b0;
      rsp_vld   <= '0;
      case (state)
        ST_IDLE: begin
          if (any_req) begin
            win       <= pick;
            gnt       <= onehot(pick);
            eng_i_vld <= 1'b1;
            eng_i0    <= pick_ops[0*OP_W +: OP_W];
            eng_i1    <= pick_ops[1*OP_W +: OP_W];
            eng_i2    <= pick_ops[2*OP_W +: OP_W];
            eng_i3    <= pick_ops[3*OP_W +: OP_W];
            eng_sel   <= pick_sel;
            state     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          timer <= '0;
          ptr   <= (int'(win) == N - 1) ? '0 : win + 1'b1;
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          // A result arriving on the terminal timer cycle still counts.
          if (eng_o_vld) begin
            rsp_y   <= eng_y;
            rsp_err <= 1'b0;
            rsp_vld <= onehot(win);
            state   <= ST_RESP;
          end else if (timer == 8'(TIMEOUT)) begin
            rsp_y   <= '0;
            rsp_err <= 1'b1;
            rsp_vld <= onehot(win);
            state   <= ST_RESP;
          end else begin
            timer <= timer + 8'd1;
          end
        end
        ST_RESP: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/mux_req_arbiter.md
Name: mux_req_arbiter

Overview:
- Round-robin arbiter/sequencer that shares one mux_4to1_4bit engine among N requesters.
- Accepts one request at a time and issues it to the engine as a single i_vld pulse with the operands and select.
- Waits for the engine's o_vld, then routes the 4-bit result back to the winning requester.
- A timeout guards against a non-responding engine; sits between client blocks and the engine instance.

Parameters:
- N, 4: number of requesters (2..8).
- TIMEOUT, 15: maximum WAIT cycles before an error response (1..255).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  N  per-client request; held until the matching gnt bit.
- req_ops  input  16*N  client k operands {i3,i2,i1,i0} at bits [16k+15:16k].
- req_sel  input  2*N  client k select at bits [2k+1:2k].
- gnt  output  N  one-hot, one-cycle pulse; the request is accepted.
- rsp_vld  output  N  one-hot, one-cycle pulse; the response is for that client.
- rsp_y  output  4  result; valid when any rsp_vld bit is high.
- rsp_err  output  1  timeout flag; qualified by rsp_vld.
- busy  output  1  high in any state other than IDLE.
- eng_i_vld  output  1  to engine i_vld.
- eng_i0, eng_i1, eng_i2, eng_i3  output  4 each  to engine operands.
- eng_sel  output  2  to engine sel.
- eng_y  input  4  from engine y.
- eng_o_vld  input  1  from engine o_vld.

Behaviour:
- All outputs are registered. Reset (async, rst_n low) forces:
  - state IDLE, RR pointer 0, timer 0;
  - gnt, rsp_vld, rsp_y, rsp_err, eng_i_vld, eng_i*, eng_sel all 0.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If req is nonzero, pick the winner: first set bit scanning from pointer upward, wrapping modulo N.
  - Latch winner index, operands and select. Next state ISSUE.
  - Register gnt[winner]=1, eng_i_vld=1 and the eng_i*/eng_sel operands so they are visible during ISSUE.
- ISSUE:
  - gnt and eng_i_vld high exactly this cycle; cleared on the next edge.
  - Timer cleared. Pointer = (winner+1) mod N. Next state WAIT.
- WAIT:
  - eng_o_vld=1: capture eng_y and clear err; next state RESP.
  - Otherwise timer++. If timer reaches TIMEOUT with no eng_o_vld: err=1, y=0, next state RESP.
  - If eng_o_vld arrives in the same cycle the timer hits TIMEOUT, eng_o_vld wins and there is no error.
- RESP:
  - rsp_vld[winner], rsp_y and rsp_err driven this cycle only. Next state IDLE.
  - rsp_y holds its value until the next response.
- eng_o_vld outside WAIT is ignored; a late result after a timeout is dropped.
- eng_i* and eng_sel hold their last issued values between requests.
- Latency, with the engine answering 3 cycles after capture:
  - req seen in cycle 0; gnt and eng_i_vld in cycle 1.
  - eng_o_vld in cycle 4; rsp_vld in cycle 5.
  - Back in IDLE in cycle 6; next gnt earliest in cycle 7.
- req changing while busy is not sampled. Clients must keep req and data stable until gnt.
- A client deasserting req before gnt simply loses arbitration; this is not an error.
- Pointer update happens only on grant. Fairness: any continuously requesting client is granted within N grants.
- Reset mid-transaction: abort immediately, no response issued. The engine shares rst_n, so it resets too.

Decomposition:
- Shared package mux_arb_pkg:
  - state encoding (IDLE=0, ISSUE=1, WAIT=2, RESP=3);
  - OP_W=4, SEL_W=2;
  - default TIMEOUT.
- One natural sub-module: rr_pick.
  - Combinational round-robin picker: inputs req[N] and ptr; outputs winner index and any_req.
  - Parameterised on N; used in IDLE.

Test Plan:
- Single request: req=4'b0010, client1 ops {i3..i0}={9,7,5,3}, sel=2. Expect gnt=4'b0010 in cycle 1, eng_i_vld with eng_i2=7/eng_sel=2, then rsp_vld=4'b0010, rsp_y=7, rsp_err=0 in cycle 5.
- Round-robin: req=4'b1111 held, each client k has i_k=k+1 and sel=k. Grant order is clients 0,1,2,3,0, with rsp_y 1,2,3,4,1 respectively.
- Pointer wrap: grant client 3, then req=4'b1001. Next grant must be client 0, then client 3.
- Timeout: engine stubbed to never assert o_vld. rsp_vld for the winner arrives TIMEOUT+1 cycles after entering WAIT, with rsp_err=1 and rsp_y=0. A stub o_vld pulse 5 cycles later is ignored; state stays IDLE.
- Boundary: eng_o_vld in the exact cycle the timer hits TIMEOUT. Expect rsp_err=0 and rsp_y=eng_y.
- Reset mid-WAIT: rst_n low for 2 cycles. All outputs go to 0 immediately and no rsp_vld appears. After release, req=4'b0100 is granted in 1 cycle (pointer back at 0).
